// File: rtl/dram_port_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data RAM.
// Commands are registered onto the DRAM bus; read responses come back tagged to their port.
module dram_port_arbiter #(
    parameter int unsigned ADDR_W   = 18,
    parameter int unsigned DATA_W   = 9,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic              mem_off,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnP0   = 2'd1,
        OwnP1   = 2'd2
    } owner_e;

    owner_e              owner_q, owner_d;
    logic                last_q, last_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                xfer0, xfer1;

    logic                mem_we_q, mem_we_d;
    logic                mem_off_q, mem_off_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    // Tag of the command currently on the bus, then RD_LAT stages of {valid, port}.
    logic                cmd_rd_q, cmd_rd_d;
    logic                cmd_port_q, cmd_port_d;
    logic [RD_LAT-1:0]   pv_q, pv_d;
    logic [RD_LAT-1:0]   pp_q, pp_d;
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;

    assign gnt0  = (owner_q == OwnP0);
    assign gnt1  = (owner_q == OwnP1);
    assign xfer0 = req0 & gnt0;
    assign xfer1 = req1 & gnt1;

    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (owner_q)
            OwnNone: begin
                hold_d = '0;
                if (req0 && req1) begin
                    owner_d = last_q ? OwnP0 : OwnP1;
                end else if (req0) begin
                    owner_d = OwnP0;
                end else if (req1) begin
                    owner_d = OwnP1;
                end
            end
            OwnP0: begin
                if (req0) begin
                    if (hold_q == HOLD_MAX && req1) begin
                        owner_d = OwnP1;
                        hold_d  = '0;
                        last_d  = 1'b0;
                    end else if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end else begin
                    owner_d = req1 ? OwnP1 : OwnNone;
                    hold_d  = '0;
                    last_d  = 1'b0;
                end
            end
            OwnP1: begin
                if (req1) begin
                    if (hold_q == HOLD_MAX && req0) begin
                        owner_d = OwnP0;
                        hold_d  = '0;
                        last_d  = 1'b1;
                    end else if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end else begin
                    owner_d = req0 ? OwnP0 : OwnNone;
                    hold_d  = '0;
                    last_d  = 1'b1;
                end
            end
            default: begin
                owner_d = OwnNone;
                hold_d  = '0;
            end
        endcase
    end

    always_comb begin
        mem_we_d    = 1'b0;
        mem_off_d   = 1'b1;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cmd_rd_d    = 1'b0;
        cmd_port_d  = 1'b0;
        if (xfer0) begin
            mem_we_d    = we0;
            mem_off_d   = 1'b0;
            mem_addr_d  = addr0;
            mem_wdata_d = wdata0;
            cmd_rd_d    = ~we0;
        end else if (xfer1) begin
            mem_we_d    = we1;
            mem_off_d   = 1'b0;
            mem_addr_d  = addr1;
            mem_wdata_d = wdata1;
            cmd_rd_d    = ~we1;
            cmd_port_d  = 1'b1;
        end
    end

    always_comb begin
        pv_d    = '0;
        pp_d    = '0;
        pv_d[0] = cmd_rd_q;
        pp_d[0] = cmd_port_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pp_d[i] = pp_q[i-1];
        end
        rvalid0_d = pv_q[RD_LAT-1] & ~pp_q[RD_LAT-1];
        rvalid1_d = pv_q[RD_LAT-1] &  pp_q[RD_LAT-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= OwnNone;
            last_q      <= 1'b1;
            hold_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_off_q   <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cmd_rd_q    <= 1'b0;
            cmd_port_q  <= 1'b0;
            pv_q        <= '0;
            pp_q        <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            mem_we_q    <= mem_we_d;
            mem_off_q   <= mem_off_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cmd_rd_q    <= cmd_rd_d;
            cmd_port_q  <= cmd_port_d;
            pv_q        <= pv_d;
            pp_q        <= pp_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_off   = mem_off_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = mem_rdata;
    assign rdata1    = mem_rdata;

endmodule
